rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32×32 register file write port. Two producers share the register file's single write port: the ALU result path and the load-data path. The block grants one of them per cycle with round-robin fairness and drives the registered `rf_we/rf_wa/rf_wd` into the register file. It also keeps a per-register pending-write mask, which the issue logic uses for hazard stalls.

---
 rtl/rf_wb_arbiter_pkg.sv | 16 +
 rtl/rf_wb_arbiter_if.sv | 30 +++
 rtl/rf_wb_arbiter_rr_arb2.sv | 30 +++
 rtl/rf_wb_arbiter.sv | 90 +++++++++
 tb/tb_rf_wb_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Widths here match the 32x32 integer register file.
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  localparam logic [ADDR_W-1:0] RF_ZERO = '0;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle for the two producers (ALU result and load data).
// The producers drive the master side; the arbiter consumes the slave side.
interface rf_wb_arbiter_if;
  import rf_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wa;
  logic [DATA_W-1:0] alu_wd;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_wa, alu_wd,
    input  alu_ready,
    output mem_valid, mem_wa, mem_wd,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    output alu_ready,
    input  mem_valid, mem_wa, mem_wd,
    output mem_ready
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the ALU, bit 1 the load path.
// The pointer moves only when the winning request actually transfers.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  wb_src_e last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == WB_MEM) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last <= WB_MEM;
    end else if (advance) begin
      last <= gnt[1] ? WB_MEM : WB_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register-file write port, with a registered write
// stage and the per-register pending-write scoreboard used for issue stalls.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int NREG   = rf_pkg::NREG
) (
  input  logic               clk,
  input  logic               rstn,
  rf_wb_arbiter_if.slave     wb,
  input  logic               issue_en,
  input  logic [ADDR_W-1:0]  issue_wa,
  input  logic               flush,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_wa,
  output logic [DATA_W-1:0]  rf_wd,
  output logic [NREG-1:0]    busy_mask
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_wa;
  logic [DATA_W-1:0] sel_wd;
  logic [NREG-1:0]   busy_next;

  assign req = {wb.mem_valid, wb.alu_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  // Grants are a subset of requests, so a high ready always means a transfer.
  assign wb.alu_ready = gnt[0] & rstn;
  assign wb.mem_ready = gnt[1] & rstn;
  assign xfer         = wb.alu_ready | wb.mem_ready;

  always_comb begin
    sel_wa = wb.alu_wa;
    sel_wd = wb.alu_wd;
    if (gnt[1]) begin
      sel_wa = wb.mem_wa;
      sel_wd = wb.mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (xfer) begin
      rf_we <= (sel_wa != RF_ZERO);
      rf_wa <= sel_wa;
      rf_wd <= sel_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // A new issue to the register being written wins: its producer is still pending.
  always_comb begin
    busy_next = busy_mask;
    if (rf_we) begin
      busy_next[rf_wa] = 1'b0;
    end
    if (issue_en && (issue_wa != RF_ZERO)) begin
      busy_next[issue_wa] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_wa;
  logic              flush;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic [NREG-1:0]   busy_mask;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_arbiter_if wb ();

  rf_wb_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .wb        (wb),
    .issue_en  (issue_en),
    .issue_wa  (issue_wa),
    .flush     (flush),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wb.alu_valid = 1'b0;
    wb.alu_wa    = '0;
    wb.alu_wd    = '0;
    wb.mem_valid = 1'b0;
    wb.mem_wa    = '0;
    wb.mem_wd    = '0;
    issue_en     = 1'b0;
    issue_wa     = '0;
    flush        = 1'b0;
  endtask

  task automatic chk_ready(input string name, input logic exp_alu, input logic exp_mem);
    settle();
    n_cmp++;
    if ({wb.alu_ready, wb.mem_ready} !== {exp_alu, exp_mem}) begin
      n_err++;
      $display("FAIL %s ready: got alu=%b mem=%b want alu=%b mem=%b", name,
               wb.alu_ready, wb.mem_ready, exp_alu, exp_mem);
    end
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    wb.alu_valid = 1'b1;
    wb.mem_valid = 1'b1;
    chk_ready("reset", 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd, busy_mask} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
      n_err++;
      $display("FAIL reset_regs: got we=%b wa=%0d wd=%h mask=%h want all zero",
               rf_we, rf_wa, rf_wd, busy_mask);
    end
    idle();
    rstn = 1'b1;
    step();
  endtask

  task automatic pulse_reset();
    idle();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_lone_alu();
    idle();
    wb.alu_valid = 1'b1;
    wb.alu_wa    = 5'd5;
    wb.alu_wd    = 32'h0000_1234;
    chk_ready("lone_alu", 1'b1, 1'b0);
    step();
    idle();
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      n_err++;
      $display("FAIL lone_alu_write: got we=%b wa=%0d wd=%h want we=1 wa=5 wd=00001234",
               rf_we, rf_wa, rf_wd);
    end
    step();
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd5, 32'h0000_1234}) begin
      n_err++;
      $display("FAIL lone_alu_hold: got we=%b wa=%0d wd=%h want we=0 wa=5 wd=00001234",
               rf_we, rf_wa, rf_wd);
    end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] exp_wa;
    logic [DATA_W-1:0] exp_wd;
    pulse_reset();
    wb.alu_valid = 1'b1;
    wb.alu_wa    = 5'd1;
    wb.alu_wd    = 32'hA1A1_0001;
    wb.mem_valid = 1'b1;
    wb.mem_wa    = 5'd2;
    wb.mem_wd    = 32'hB2B2_0002;
    for (int i = 0; i < 4; i++) begin
      chk_ready($sformatf("contention%0d", i), (i % 2) == 0, (i % 2) == 1);
      exp_wa = ((i % 2) == 0) ? 5'd1 : 5'd2;
      exp_wd = ((i % 2) == 0) ? 32'hA1A1_0001 : 32'hB2B2_0002;
      step();
      n_cmp++;
      if ({rf_we, rf_wa, rf_wd} !== {1'b1, exp_wa, exp_wd}) begin
        n_err++;
        $display("FAIL contention%0d_write: got we=%b wa=%0d wd=%h want we=1 wa=%0d wd=%h",
                 i, rf_we, rf_wa, rf_wd, exp_wa, exp_wd);
      end
    end
    idle();
    step();
  endtask

  task automatic test_x0_write();
    idle();
    issue_en = 1'b1;
    issue_wa = 5'd3;
    step();
    idle();
    wb.mem_valid = 1'b1;
    wb.mem_wa    = 5'd0;
    wb.mem_wd    = 32'hFFFF_FFFF;
    chk_ready("x0", 1'b0, 1'b1);
    step();
    idle();
    n_cmp++;
    if ({rf_we, busy_mask} !== {1'b0, 32'h0000_0008}) begin
      n_err++;
      $display("FAIL x0_write: got we=%b mask=%h want we=0 mask=00000008", rf_we, busy_mask);
    end
    issue_en = 1'b1;
    issue_wa = 5'd0;
    step();
    idle();
    n_cmp++;
    if (busy_mask !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL issue_x0: got mask=%h want 00000008", busy_mask);
    end
    flush = 1'b1;
    step();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    issue_en = 1'b1;
    issue_wa = 5'd7;
    step();
    idle();
    n_cmp++;
    if (busy_mask !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL sb_set: got mask=%h want 00000080", busy_mask);
    end
    wb.alu_valid = 1'b1;
    wb.alu_wa    = 5'd7;
    wb.alu_wd    = 32'h0000_0077;
    step();
    idle();
    n_cmp++;
    if ({rf_we, rf_wa, busy_mask} !== {1'b1, 5'd7, 32'h0000_0080}) begin
      n_err++;
      $display("FAIL sb_write_stage: got we=%b wa=%0d mask=%h want we=1 wa=7 mask=00000080",
               rf_we, rf_wa, busy_mask);
    end
    step();
    n_cmp++;
    if (busy_mask !== 32'h0) begin
      n_err++;
      $display("FAIL sb_clear: got mask=%h want 00000000", busy_mask);
    end
    issue_en = 1'b1;
    issue_wa = 5'd7;
    step();
    idle();
    wb.alu_valid = 1'b1;
    wb.alu_wa    = 5'd7;
    wb.alu_wd    = 32'h0000_0078;
    step();
    idle();
    issue_en = 1'b1;
    issue_wa = 5'd7;
    step();
    idle();
    n_cmp++;
    if (busy_mask !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL sb_set_wins: got mask=%h want 00000080", busy_mask);
    end
    flush = 1'b1;
    step();
    idle();
  endtask

  task automatic test_flush();
    idle();
    for (int r = 4; r < 8; r++) begin
      issue_en = 1'b1;
      issue_wa = ADDR_W'(r);
      step();
    end
    idle();
    n_cmp++;
    if (busy_mask !== 32'h0000_00F0) begin
      n_err++;
      $display("FAIL flush_pre: got mask=%h want 000000f0", busy_mask);
    end
    wb.mem_valid = 1'b1;
    wb.mem_wa    = 5'd4;
    wb.mem_wd    = 32'h0000_CAFE;
    step();
    idle();
    flush    = 1'b1;
    issue_en = 1'b1;
    issue_wa = 5'd9;
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd4, 32'h0000_CAFE}) begin
      n_err++;
      $display("FAIL flush_write: got we=%b wa=%0d wd=%h want we=1 wa=4 wd=0000cafe",
               rf_we, rf_wa, rf_wd);
    end
    step();
    idle();
    n_cmp++;
    if (busy_mask !== 32'h0) begin
      n_err++;
      $display("FAIL flush_mask: got mask=%h want 00000000", busy_mask);
    end
    wb.alu_valid = 1'b1;
    wb.alu_wa    = 5'd3;
    wb.alu_wd    = 32'h0000_0033;
    flush        = 1'b1;
    step();
    idle();
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h0000_0033}) begin
      n_err++;
      $display("FAIL flush_same_cycle: got we=%b wa=%0d wd=%h want we=1 wa=3 wd=00000033",
               rf_we, rf_wa, rf_wd);
    end
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 3; i++) begin
      wb.alu_valid = 1'b1;
      wb.alu_wa    = ADDR_W'(20 + i);
      wb.alu_wd    = 32'h1000 + i;
      step();
      n_cmp++;
      if ({rf_we, rf_wa, rf_wd} !== {1'b1, ADDR_W'(20 + i), 32'h1000 + i}) begin
        n_err++;
        $display("FAIL b2b%0d: got we=%b wa=%0d wd=%h want we=1 wa=%0d wd=%h",
                 i, rf_we, rf_wa, rf_wd, 20 + i, 32'h1000 + i);
      end
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    issue_en = 1'b1;
    issue_wa = 5'd10;
    step();
    idle();
    wb.alu_valid = 1'b1;
    wb.alu_wa    = 5'd8;
    wb.alu_wd    = 32'h0000_0088;
    step();
    rstn         = 1'b0;
    wb.alu_wa    = 5'd11;
    wb.alu_wd    = 32'h0000_00BB;
    wb.mem_valid = 1'b1;
    wb.mem_wa    = 5'd12;
    wb.mem_wd    = 32'h0000_00CC;
    chk_ready("mid_reset", 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({rf_we, rf_wa, busy_mask} !== {1'b0, 5'd0, 32'h0}) begin
      n_err++;
      $display("FAIL mid_reset_regs: got we=%b wa=%0d mask=%h want we=0 wa=0 mask=00000000",
               rf_we, rf_wa, busy_mask);
    end
    rstn = 1'b1;
    chk_ready("post_reset_tie", 1'b1, 1'b0);
    step();
    n_cmp++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd11, 32'h0000_00BB}) begin
      n_err++;
      $display("FAIL post_reset_write: got we=%b wa=%0d wd=%h want we=1 wa=11 wd=000000bb",
               rf_we, rf_wa, rf_wd);
    end
    wb.alu_valid = 1'b1;
    chk_ready("post_reset_next", 1'b0, 1'b1);
    step();
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_lone_alu();
    test_contention();
    test_x0_write();
    test_scoreboard();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
